// File: rtl/mips_phase_pkg.sv
// mips_phase_pkg: shared state encoding and default phase lengths
// for the mips_uniciclo phase generator.
package mips_phase_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PC,
    S_INST,
    S_DATA,
    S_REG,
    S_DONE
  } phase_t;

  localparam int PC_TICKS_DEF   = 1;
  localparam int INST_TICKS_DEF = 5;
  localparam int DATA_TICKS_DEF = 5;
  localparam int REG_TICKS_DEF  = 1;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Counter holds TICKS-1, so it needs clog2(max ticks) bits.
  function automatic int tick_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mips_phase_gen_if.sv
// mips_phase_gen_if: control/status bundle of the phase generator.
// master = controller side (run/step/limit), slave = generator side.
interface mips_phase_gen_if #(
  parameter int CNT_W = 16
) ();

  logic             run_enable;
  logic [CNT_W-1:0] max_cycles;
  logic             step;
  logic             pc_clock;
  logic             inst_clock;
  logic             data_clock;
  logic             reg_clock;
  logic [CNT_W-1:0] cycle_count;
  logic             busy;
  logic             done;

  modport master (
    output run_enable,
    output max_cycles,
    output step,
    input  pc_clock,
    input  inst_clock,
    input  data_clock,
    input  reg_clock,
    input  cycle_count,
    input  busy,
    input  done
  );

  modport slave (
    input  run_enable,
    input  max_cycles,
    input  step,
    output pc_clock,
    output inst_clock,
    output data_clock,
    output reg_clock,
    output cycle_count,
    output busy,
    output done
  );

endinterface

// File: rtl/mips_tick_counter.sv
// mips_tick_counter: loadable down-counter with zero flag.
// Ports: clock, reset_n, load/load_val, dec, zero.
module mips_tick_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mips_phase_gen.sv
// mips_phase_gen: PC/INST/DATA/REG phase strobe sequencer with cycle
// counter and limit. Ports: clock, reset_n, bus (slave). Macro:
// MIPS_PHASE_GEN_STEP_EN enables rising-edge single-step on bus.step.
module mips_phase_gen
  import mips_phase_pkg::*;
#(
  parameter int PC_TICKS   = PC_TICKS_DEF,
  parameter int INST_TICKS = INST_TICKS_DEF,
  parameter int DATA_TICKS = DATA_TICKS_DEF,
  parameter int REG_TICKS  = REG_TICKS_DEF,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  mips_phase_gen_if.slave   bus
);

  localparam int TMAX =
    max4(PC_TICKS, INST_TICKS, DATA_TICKS, REG_TICKS);
  localparam int TW = tick_w(TMAX);

  typedef logic [TW-1:0] tick_t;

  phase_t           state;
  phase_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] limit;
  logic             ended_done;
  logic             limit_hit;
  logic             start;
  logic             zero;
  logic             load;
  tick_t            load_val;
  logic             pc_q;
  logic             inst_q;
  logic             data_q;
  logic             reg_q;
  logic             busy_q;
  logic             done_q;

  function automatic tick_t ticks_of(input phase_t s);
    unique case (s)
      S_PC:    return tick_t'(PC_TICKS - 1);
      S_INST:  return tick_t'(INST_TICKS - 1);
      S_DATA:  return tick_t'(DATA_TICKS - 1);
      S_REG:   return tick_t'(REG_TICKS - 1);
      default: return '0;
    endcase
  endfunction

`ifdef MIPS_PHASE_GEN_STEP_EN
  logic step_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= bus.step;
    end
  end

  assign start = bus.run_enable | (bus.step & ~step_q);
`else
  logic unused_step;

  assign unused_step = bus.step;
  assign start       = bus.run_enable;
`endif

  // Saturating increment; only reachable at all-ones when unlimited.
  assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign limit_hit = (limit != '0) && (cnt_inc == limit);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start) nxt = S_PC;
      S_PC:   if (zero) nxt = S_INST;
      S_INST: if (zero) nxt = S_DATA;
      S_DATA: if (zero) nxt = S_REG;
      S_REG: begin
        if (zero) begin
          if (limit_hit)           nxt = S_DONE;
          else if (bus.run_enable) nxt = S_PC;
          else                     nxt = S_IDLE;
        end
      end
      S_DONE: if (!bus.run_enable) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Reload the tick counter whenever a phase is entered.
  assign load     = (nxt != state) &&
                    (nxt inside {S_PC, S_INST, S_DATA, S_REG});
  assign load_val = ticks_of(nxt);

  mips_tick_counter #(
    .W (TW)
  ) u_ticks (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .dec      (busy_q),
    .zero     (zero)
  );

  // Outputs register the next state so strobes come straight from flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      pc_q       <= 1'b0;
      inst_q     <= 1'b0;
      data_q     <= 1'b0;
      reg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt        <= '0;
      limit      <= '0;
      ended_done <= 1'b0;
    end else begin
      state  <= nxt;
      pc_q   <= (nxt == S_PC);
      inst_q <= (nxt == S_INST);
      data_q <= (nxt == S_DATA);
      reg_q  <= (nxt == S_REG);
      busy_q <= nxt inside {S_PC, S_INST, S_DATA, S_REG};
      done_q <= (nxt == S_DONE);
      if ((state == S_IDLE) && start) begin
        limit      <= bus.max_cycles;
        ended_done <= 1'b0;
        if (ended_done) cnt <= '0;
      end
      if ((state == S_REG) && zero) begin
        cnt <= cnt_inc;
        if (limit_hit) ended_done <= 1'b1;
      end
    end
  end

  assign bus.pc_clock    = pc_q;
  assign bus.inst_clock  = inst_q;
  assign bus.data_clock  = data_q;
  assign bus.reg_clock   = reg_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cycle_count = cnt;

endmodule

// File: doc/mips_phase_gen.md
MIPS_PHASE_GEN -- requirements
Module: mips_phase_gen

Interface
REQ-001 SHALL have parameter PC_TICKS, default 1, pc_clock phase length in clock periods (>=1).
REQ-002 SHALL have parameter INST_TICKS, default 5, inst_clock phase length (>=1).
REQ-003 SHALL have parameter DATA_TICKS, default 5, data_clock phase length (>=1).
REQ-004 SHALL have parameter REG_TICKS, default 1, reg_clock phase length (>=1).
REQ-005 SHALL have parameter CNT_W, default 16, width of cycle counter and limit.
REQ-006 Ports: clock  in  1  single system clock; all logic on its rising edge.
REQ-007 Ports: reset_n  in  1  asynchronous, active-low reset.
REQ-008 Ports: run_enable  in  1  level; request continuous instruction cycles.
REQ-009 Ports: max_cycles  in  CNT_W  cycle limit; 0 = unlimited; sampled on IDLE->PC.
REQ-010 Ports: step  in  1  single-step request (see Configuration).
REQ-011 Ports: pc_clock, inst_clock, data_clock, reg_clock  out  1 each  phase strobes to mips_uniciclo.
REQ-012 Ports: cycle_count  out  CNT_W  completed instruction cycles.
REQ-013 Ports: busy  out  1  high in any phase state; done  out  1  limit reached.

Function
REQ-014 FSM states SHALL be IDLE, PC, INST, DATA, REG, DONE; phase order fixed PC->INST->DATA->REG.
REQ-015 Each phase state SHALL last exactly its *_TICKS periods, timed by a loadable down-counter; one instruction cycle = sum of ticks (12 by default).
REQ-016 Each strobe SHALL be high exactly while FSM is in its phase state; at most one strobe high at any time; strobes driven directly from flops (no combinational decode glitches).
REQ-017 IDLE->PC SHALL occur at the edge where run_enable=1 is sampled; pc_clock high from that edge on.
REQ-018 REG end: cycle_count SHALL increment; then DONE if max_cycles!=0 and new count==latched limit, else PC if run_enable=1, else IDLE.
REQ-019 run_enable falling mid-cycle SHALL NOT truncate phases; current cycle completes through REG, then IDLE.
REQ-020 DONE SHALL hold done=1, all strobes 0, until run_enable=0, then IDLE with done=0.
REQ-021 cycle_count SHALL clear on IDLE->PC only when the previous run ended in DONE; otherwise it accumulates; saturates at all-ones with max_cycles=0.
REQ-022 busy SHALL be 1 in PC/INST/DATA/REG, 0 in IDLE/DONE.
REQ-023 max_cycles changes during a run SHALL be ignored until next IDLE->PC.

Reset
REQ-024 reset_n=0 SHALL immediately force IDLE, all strobes 0, busy 0, done 0, cycle_count 0, tick counter 0, regardless of phase.
REQ-025 After reset_n release, first transition SHALL require run_enable (or step) sampled high at a rising edge.

Configuration
REQ-026 Macro MIPS_PHASE_GEN_STEP_EN defined: step=1 sampled in IDLE with run_enable=0 SHALL launch exactly one instruction cycle, increment cycle_count, return to IDLE; step held high launches one cycle per fall-rise of step (rising-edge detected).
REQ-027 Macro undefined: step port present but ignored; no edge-detect flop.

Structure
REQ-028 Shared package mips_phase_pkg SHALL hold the state enum and default tick constants (1/5/5/1).
REQ-029 Sub-module mips_tick_counter (loadable down-counter with zero flag) SHALL time phases.

Verification
REQ-030 Reset asserted mid-DATA -> all outputs 0 without a clock edge; count 0.
REQ-031 run_enable=1, max_cycles=3 -> strobe sequence 1/5/5/1 clocks, three times (36 clocks), then done=1, busy=0, cycle_count=3.
REQ-032 run_enable dropped on 2nd INST tick -> INST/DATA/REG complete, cycle_count=1, IDLE, no further pc_clock.
REQ-033 DONE then run_enable 0->1 -> cycle_count clears to 0, new run starts, done=0.
REQ-034 With MIPS_PHASE_GEN_STEP_EN, step pulsed twice -> exactly 2 cycles (24 strobe clocks), cycle_count=2; without macro -> no strobes, count 0.
REQ-035 CNT_W=4, max_cycles=0, run 20 cycles -> cycle_count saturates at 0xF, strobes continue, done=0.
